// File: rtl/i2c_slave_ctl_pkg.sv
// i2c_slave_ctl_pkg
// Shared definitions for the I2C target engine. It holds the slave FSM state
// encodings, the ACK/NACK bus levels and the address compare helper.
package i2c_slave_ctl_pkg;

    // Slave FSM state encodings
    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_ADDR     = 4'd1;
    localparam logic [3:0] S_ADDR_ACK = 4'd2;
    localparam logic [3:0] S_RX       = 4'd3;
    localparam logic [3:0] S_RX_ACK   = 4'd4;
    localparam logic [3:0] S_TX_LOAD  = 4'd5;
    localparam logic [3:0] S_TX_WAIT  = 4'd6;
    localparam logic [3:0] S_TX       = 4'd7;
    localparam logic [3:0] S_TX_ACK   = 4'd8;
    localparam logic [3:0] S_IGNORE   = 4'd9;

    // Level on SDA during the acknowledge slot
    localparam logic BIT_ACK  = 1'b0;
    localparam logic BIT_NACK = 1'b1;

    // The upper seven bits of the first byte carry the target address
    function automatic logic addr_match(input logic [7:0] first_byte, input logic [6:0] own_addr);
        return first_byte[7:1] == own_addr;
    endfunction

endpackage

// File: rtl/i2c_slave_ctl_line_filter.sv
// i2c_line_filter
// Brings one I2C pad into the system clock domain and removes short glitches.
// The filtered level only changes after FILT_LEN consecutive equal
// synchronised samples; rise/fall pulses coincide with the level change.
// Pad change to level/pulse latency is 2+FILT_LEN clocks.
// Ports:
//   clk_i   : system clock
//   rst_i   : synchronous active-high reset (level presets to 1)
//   pad_i   : raw pad input
//   level_o : filtered level
//   rise_o  : 1-cycle pulse when level_o goes 0->1
//   fall_o  : 1-cycle pulse when level_o goes 1->0
module i2c_line_filter #(
    parameter int FILT_LEN = 3
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic pad_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    // sync_q is the first synchroniser flop; win_q[0] doubles as the second
    // flop, so the window holds FILT_LEN synchronised samples.
    logic                sync_q;
    logic [FILT_LEN-1:0] win_q, win_d;
    logic                level_q, level_d;
    logic                rise_q, fall_q;

    always_comb begin
        win_d[0] = sync_q;
        for (int i = 1; i < FILT_LEN; i++) begin
            win_d[i] = win_q[i-1];
        end
        level_d = level_q;
        if (&win_q) begin
            level_d = 1'b1;
        end else if (~|win_q) begin
            level_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q  <= 1'b1;
            win_q   <= '1;
            level_q <= 1'b1;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= pad_i;
            win_q   <= win_d;
            level_q <= level_d;
            rise_q  <= level_d & ~level_q;
            fall_q  <= ~level_d & level_q;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/i2c_slave_ctl.sv
// i2c_slave_ctl
// I2C target engine. Filters SCL/SDA, detects START/STOP, matches a 7-bit
// address and moves bytes between the bus and a local rx/tx interface.
// The bus is driven open-drain through output enables only (0 = pull low).
// Ports:
//   i_sysclk, i_reset      : clock, synchronous active-high reset
//   i_enable               : 0 = FSM idle, both lines released
//   i_addr                 : own 7-bit address
//   i_scl/o_scl_oen        : SCL pad in, SCL enable (0 = stretch)
//   i_sda/o_sda_oen        : SDA pad in, SDA enable (0 = drive low)
//   o_rx_data/o_rx_valid   : received byte and its 1-cycle strobe
//   i_rx_nack              : 1 = NACK the byte just received
//   i_tx_data/i_tx_valid   : next byte for a master read
//   o_tx_ready             : 1-cycle pulse when i_tx_data was taken
//   o_addressed, o_rw      : address matched flag and its R/W bit
//   o_start, o_stop, o_busy: bus event pulses and bus-busy flag
// Handshake: o_rx_valid is a strobe with no back-pressure; a tx byte is taken
// while i_tx_valid is high in a load slot, and o_tx_ready pulses once for it.
module i2c_slave_ctl
    import i2c_slave_ctl_pkg::*;
#(
    parameter int FILT_LEN = 3
) (
    input  logic       i_sysclk,
    input  logic       i_reset,
    input  logic       i_enable,
    input  logic [6:0] i_addr,
    input  logic       i_scl,
    output logic       o_scl_oen,
    input  logic       i_sda,
    output logic       o_sda_oen,
    output logic [7:0] o_rx_data,
    output logic       o_rx_valid,
    input  logic       i_rx_nack,
    input  logic [7:0] i_tx_data,
    input  logic       i_tx_valid,
    output logic       o_tx_ready,
    output logic       o_addressed,
    output logic       o_rw,
    output logic       o_start,
    output logic       o_stop,
    output logic       o_busy
);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
        .clk_i(i_sysclk), .rst_i(i_reset), .pad_i(i_scl),
        .level_o(scl_lvl), .rise_o(scl_rise), .fall_o(scl_fall)
    );

    i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
        .clk_i(i_sysclk), .rst_i(i_reset), .pad_i(i_sda),
        .level_o(sda_lvl), .rise_o(sda_rise), .fall_o(sda_fall)
    );

    logic [3:0] state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       phase_q, phase_d;   // 0: ACK slot not yet driven, 1: release on next fall
    logic       nack_q, nack_d;
    logic       sda_oen_q, sda_oen_d;
    logic       scl_oen_q, scl_oen_d;
    logic       addressed_q, addressed_d;
    logic       rw_q, rw_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       tx_ready_q, tx_ready_d;
    logic       start_q, start_d;
    logic       stop_q, stop_d;
    logic       busy_q, busy_d;

    logic       start_det, stop_det;
    logic       tx_eval, tx_load;
    logic [7:0] rx_byte;

    assign start_det = sda_fall & scl_lvl;
    assign stop_det  = sda_rise & scl_lvl;
    assign rx_byte   = {shift_q[6:0], sda_lvl};

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        phase_d     = phase_q;
        nack_d      = nack_q;
        sda_oen_d   = sda_oen_q;
        scl_oen_d   = scl_oen_q;
        addressed_d = addressed_q;
        rw_d        = rw_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        tx_ready_d  = 1'b0;
        start_d     = start_det;
        stop_d      = stop_det;
        busy_d      = busy_q;
        tx_eval     = 1'b0;
        tx_load     = 1'b0;

        // Bus busy follows bus events even while the engine is disabled
        if (start_det) begin
            busy_d = 1'b1;
        end else if (stop_det) begin
            busy_d = 1'b0;
        end

        if (!i_enable) begin
            state_d     = S_IDLE;
            sda_oen_d   = 1'b1;
            scl_oen_d   = 1'b1;
            addressed_d = 1'b0;
            phase_d     = 1'b0;
        end else if (start_det) begin
            // START also overrides a rising-edge sample in the same cycle
            state_d     = S_ADDR;
            bit_cnt_d   = 3'd0;
            addressed_d = 1'b0;
            sda_oen_d   = 1'b1;
            scl_oen_d   = 1'b1;
            phase_d     = 1'b0;
        end else if (stop_det) begin
            state_d     = S_IDLE;
            addressed_d = 1'b0;
            sda_oen_d   = 1'b1;
            scl_oen_d   = 1'b1;
            phase_d     = 1'b0;
        end else begin
            case (state_q)
                S_ADDR: if (scl_rise) begin
                    shift_d   = rx_byte;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        if (addr_match(rx_byte, i_addr)) begin
                            rw_d    = rx_byte[0];
                            phase_d = 1'b0;
                            state_d = S_ADDR_ACK;
                        end else begin
                            state_d = S_IGNORE;
                        end
                    end
                end
                S_ADDR_ACK: if (scl_fall) begin
                    if (!phase_q) begin
                        sda_oen_d   = BIT_ACK;
                        addressed_d = 1'b1;
                        phase_d     = 1'b1;
                    end else begin
                        sda_oen_d = 1'b1;
                        phase_d   = 1'b0;
                        bit_cnt_d = 3'd0;
                        if (rw_q) begin
                            tx_eval = 1'b1;
                        end else begin
                            state_d = S_RX;
                        end
                    end
                end
                S_RX: if (scl_rise) begin
                    shift_d   = rx_byte;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        rx_data_d  = rx_byte;
                        rx_valid_d = 1'b1;
                        phase_d    = 1'b0;
                        state_d    = S_RX_ACK;
                    end
                end
                S_RX_ACK: if (scl_fall) begin
                    if (!phase_q) begin
                        sda_oen_d = i_rx_nack;
                        nack_d    = i_rx_nack;
                        phase_d   = 1'b1;
                    end else begin
                        sda_oen_d = 1'b1;
                        phase_d   = 1'b0;
                        bit_cnt_d = 3'd0;
                        state_d   = (nack_q == BIT_NACK) ? S_IGNORE : S_RX;
                    end
                end
                S_TX_LOAD: if (scl_fall) begin
                    tx_eval = 1'b1;
                end
                S_TX_WAIT: if (i_tx_valid) begin
                    // SCL stays held this cycle; S_TX releases it next cycle
                    tx_load = 1'b1;
                end
                S_TX: begin
                    scl_oen_d = 1'b1;
                    if (scl_fall) begin
                        if (bit_cnt_q == 3'd7) begin
                            sda_oen_d = 1'b1;
                            bit_cnt_d = 3'd0;
                            state_d   = S_TX_ACK;
                        end else begin
                            sda_oen_d = shift_q[6];
                            shift_d   = {shift_q[6:0], 1'b0};
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end
                end
                S_TX_ACK: if (scl_rise) begin
                    state_d = (sda_lvl == BIT_ACK) ? S_TX_LOAD : S_IGNORE;
                end
                S_IDLE, S_IGNORE: begin
                    sda_oen_d = 1'b1;
                    scl_oen_d = 1'b1;
                end
                default: begin
                    state_d   = S_IDLE;
                    sda_oen_d = 1'b1;
                    scl_oen_d = 1'b1;
                end
            endcase
        end

        // Load slot: take the byte now or stretch SCL until it arrives
        if (tx_eval) begin
            if (i_tx_valid) begin
                tx_load = 1'b1;
            end else begin
                scl_oen_d = 1'b0;
                state_d   = S_TX_WAIT;
            end
        end
        if (tx_load) begin
            shift_d    = i_tx_data;
            tx_ready_d = 1'b1;
            sda_oen_d  = i_tx_data[7];
            bit_cnt_d  = 3'd0;
            state_d    = S_TX;
        end
    end

    always_ff @(posedge i_sysclk) begin
        if (i_reset) begin
            state_q     <= S_IDLE;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            phase_q     <= 1'b0;
            nack_q      <= 1'b0;
            sda_oen_q   <= 1'b1;
            scl_oen_q   <= 1'b1;
            addressed_q <= 1'b0;
            rw_q        <= 1'b0;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            tx_ready_q  <= 1'b0;
            start_q     <= 1'b0;
            stop_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            phase_q     <= phase_d;
            nack_q      <= nack_d;
            sda_oen_q   <= sda_oen_d;
            scl_oen_q   <= scl_oen_d;
            addressed_q <= addressed_d;
            rw_q        <= rw_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            tx_ready_q  <= tx_ready_d;
            start_q     <= start_d;
            stop_q      <= stop_d;
            busy_q      <= busy_d;
        end
    end

    assign o_scl_oen   = scl_oen_q;
    assign o_sda_oen   = sda_oen_q;
    assign o_rx_data   = rx_data_q;
    assign o_rx_valid  = rx_valid_q;
    assign o_tx_ready  = tx_ready_q;
    assign o_addressed = addressed_q;
    assign o_rw        = rw_q;
    assign o_start     = start_q;
    assign o_stop      = stop_q;
    assign o_busy      = busy_q;

endmodule

// File: tb/tb_i2c_slave_ctl.sv
// tb_i2c_slave_ctl
// Bus-level bench for i2c_slave_ctl: a wired-AND bus, a model master,
// an rx scoreboard and a tx byte source.
module tb_i2c_slave_ctl;
    import i2c_slave_ctl_pkg::*;

    localparam int Q        = 25;    // quarter SCL period in system clocks
    localparam int WAIT_MAX = 4000;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, en;
    logic [6:0] addr;
    logic       m_scl, m_sda, glitch;
    logic       scl_pad, sda_pad;
    logic       scl_oen, sda_oen;
    logic [7:0] rx_data;
    logic       rx_valid, rx_nack;
    logic [7:0] tx_data;
    logic       tx_valid, tx_ready;
    logic       addressed, rw, start_p, stop_p, busy;

    assign scl_pad = m_scl & scl_oen & ~glitch;
    assign sda_pad = m_sda & sda_oen;

    i2c_slave_ctl #(.FILT_LEN(3)) dut (
        .i_sysclk(clk), .i_reset(rst), .i_enable(en), .i_addr(addr),
        .i_scl(scl_pad), .o_scl_oen(scl_oen), .i_sda(sda_pad), .o_sda_oen(sda_oen),
        .o_rx_data(rx_data), .o_rx_valid(rx_valid), .i_rx_nack(rx_nack),
        .i_tx_data(tx_data), .i_tx_valid(tx_valid), .o_tx_ready(tx_ready),
        .o_addressed(addressed), .o_rw(rw), .o_start(start_p), .o_stop(stop_p),
        .o_busy(busy)
    );

    // ---------------- scoreboard / monitor ----------------
    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];      // expected received bytes
    logic [7:0] tx_src_q[$];   // bytes offered to the DUT for master reads
    logic [7:0] exp_v;
    int start_cnt = 0, stop_cnt = 0, txr_cnt = 0, rxv_cnt = 0;
    int sda_low_cnt = 0, addr_cnt = 0;

    always @(negedge clk) begin
        if (rx_valid) begin
            rxv_cnt++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL rx_unexpected got=%h want=none", rx_data);
            end else begin
                exp_v = exp_q.pop_front();
                if (rx_data !== exp_v) begin
                    bad++;
                    $display("FAIL rx_data got=%h want=%h", rx_data, exp_v);
                end
            end
        end
        if (start_p)  start_cnt++;
        if (stop_p)   stop_cnt++;
        if (!sda_oen) sda_low_cnt++;
        if (addressed) addr_cnt++;
        if (tx_ready) begin
            txr_cnt++;
            if (tx_src_q.size() > 0) void'(tx_src_q.pop_front());
        end
        tx_valid = (tx_src_q.size() > 0);
        tx_data  = (tx_src_q.size() > 0) ? tx_src_q[0] : 8'h00;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1, "timeout");
    end

    // ---------------- driver tasks ----------------
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_scl_high();
        int n = 0;
        while (scl_pad !== 1'b1 && n < WAIT_MAX) begin
            cyc(1);
            n++;
        end
        if (scl_pad !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL scl_release got=%b want=1", scl_pad);
        end
    endtask

    task automatic m_bit(input logic b, input bit glitch_it, output logic s);
        m_sda = b;
        cyc(Q);
        m_scl = 1'b1;
        wait_scl_high();
        if (glitch_it) begin
            cyc(5); glitch = 1'b1; cyc(1); glitch = 1'b0; cyc(Q - 6);
        end else begin
            cyc(Q);
        end
        s = sda_pad;
        cyc(Q);
        m_scl = 1'b0;
        cyc(Q);
    endtask

    task automatic m_start();
        m_sda = 1'b1; cyc(Q);
        m_scl = 1'b1; wait_scl_high(); cyc(Q);
        m_sda = 1'b0; cyc(Q);
        m_scl = 1'b0; cyc(Q);
    endtask

    task automatic m_stop();
        m_sda = 1'b0; cyc(Q);
        m_scl = 1'b1; wait_scl_high(); cyc(Q);
        m_sda = 1'b1; cyc(Q);
    endtask

    task automatic m_write_byte(input logic [7:0] d, input int glitch_idx, output logic ack);
        logic s;
        for (int i = 0; i < 8; i++) m_bit(d[7-i], (i == glitch_idx), s);
        m_bit(1'b1, 1'b0, ack);
    endtask

    task automatic m_read_byte(input logic mack, output logic [7:0] d);
        logic s;
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            m_bit(1'b1, 1'b0, s);
            d = {d[6:0], s};
        end
        m_bit(mack, 1'b0, s);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [16:0] got;
        rst = 1'b1; en = 1'b1; addr = 7'h50; rx_nack = 1'b0;
        m_scl = 1'b1; m_sda = 1'b1; glitch = 1'b0;
        cyc(4);
        got = {scl_oen, sda_oen, rx_valid, tx_ready, addressed, rw, start_p, stop_p, busy, rx_data};
        total++;
        if (got !== {2'b11, 7'b0, 8'h00}) begin
            bad++; $display("FAIL reset_outputs got=%h want=%h", got, {2'b11, 15'h0});
        end
        total++;
        if (dut.state_q !== S_IDLE) begin
            bad++; $display("FAIL reset_state got=%0d want=%0d", dut.state_q, S_IDLE);
        end
        rst = 1'b0;
        cyc(10);
    endtask

    task automatic test_write();
        logic ack;
        int s0 = start_cnt, p0 = stop_cnt;
        m_start();
        total++;
        if (busy !== 1'b1 || start_cnt - s0 != 1) begin
            bad++; $display("FAIL wr_start got=busy%b/%0d want=busy1/1", busy, start_cnt - s0);
        end
        m_write_byte(8'hA0, -1, ack);
        total++;
        if (ack !== 1'b0 || addressed !== 1'b1) begin
            bad++; $display("FAIL wr_addr_ack got=ack%b/adr%b want=ack0/adr1", ack, addressed);
        end
        exp_q.push_back(8'h3C);
        m_write_byte(8'h3C, -1, ack);
        total++;
        if (ack !== 1'b0) begin bad++; $display("FAIL wr_data1_ack got=%b want=0", ack); end
        exp_q.push_back(8'hC3);
        m_write_byte(8'hC3, -1, ack);
        total++;
        if (ack !== 1'b0) begin bad++; $display("FAIL wr_data2_ack got=%b want=0", ack); end
        m_stop();
        cyc(10);
        total++;
        if (stop_cnt - p0 != 1 || busy !== 1'b0 || addressed !== 1'b0 || rw !== 1'b0) begin
            bad++; $display("FAIL wr_stop got=stops%0d busy%b adr%b rw%b want=stops1 busy0 adr0 rw0",
                            stop_cnt - p0, busy, addressed, rw);
        end
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL wr_rx_missing got=%0d want=0", exp_q.size()); end
    endtask

    task automatic test_wrong_addr();
        logic ack0, ack1;
        int l0 = sda_low_cnt, a0 = addr_cnt, r0 = rxv_cnt;
        m_start();
        m_write_byte(8'hA2, -1, ack0);
        m_write_byte(8'h11, -1, ack1);
        m_stop();
        cyc(10);
        total++;
        if (ack0 !== 1'b1 || ack1 !== 1'b1) begin
            bad++; $display("FAIL na_acks got=%b%b want=11", ack0, ack1);
        end
        total++;
        if (sda_low_cnt != l0 || addr_cnt != a0 || rxv_cnt != r0) begin
            bad++; $display("FAIL na_quiet got=sda%0d adr%0d rx%0d want=0 0 0",
                            sda_low_cnt - l0, addr_cnt - a0, rxv_cnt - r0);
        end
    endtask

    task automatic test_read_stretch();
        logic ack;
        logic [7:0] d;
        int t0 = txr_cnt;
        m_start();
        m_write_byte(8'hA1, -1, ack);
        total++;
        if (ack !== 1'b0) begin bad++; $display("FAIL rd_addr_ack got=%b want=0", ack); end
        fork
            m_read_byte(1'b1, d);
            begin
                cyc(100);
                total++;
                if (scl_oen !== 1'b0) begin bad++; $display("FAIL rd_stretch_early got=%b want=0", scl_oen); end
                cyc(400);
                total++;
                if (scl_oen !== 1'b0 || scl_pad !== 1'b0) begin
                    bad++; $display("FAIL rd_stretch_late got=%b%b want=00", scl_oen, scl_pad);
                end
                tx_src_q.push_back(8'h96);
            end
        join
        total++;
        if (d !== 8'h96) begin bad++; $display("FAIL rd_byte got=%h want=96", d); end
        total++;
        if (txr_cnt - t0 != 1) begin bad++; $display("FAIL rd_tx_ready got=%0d want=1", txr_cnt - t0); end
        total++;
        if (dut.state_q !== S_IGNORE || sda_oen !== 1'b1 || scl_oen !== 1'b1) begin
            bad++; $display("FAIL rd_nack_end got=st%0d sda%b scl%b want=st%0d sda1 scl1",
                            dut.state_q, sda_oen, scl_oen, S_IGNORE);
        end
        m_stop();
        cyc(10);
    endtask

    task automatic test_repeated_start();
        logic ack;
        logic [7:0] d1, d2;
        int s0 = start_cnt, p0 = stop_cnt;
        tx_src_q.push_back(8'h5A);
        tx_src_q.push_back(8'hA5);
        exp_q.push_back(8'h12);
        m_start();
        m_write_byte(8'hA0, -1, ack);
        m_write_byte(8'h12, -1, ack);
        total++;
        if (ack !== 1'b0) begin bad++; $display("FAIL rs_wr_ack got=%b want=0", ack); end
        m_start();
        m_write_byte(8'hA1, -1, ack);
        total++;
        if (ack !== 1'b0 || rw !== 1'b1) begin
            bad++; $display("FAIL rs_addr got=ack%b rw%b want=ack0 rw1", ack, rw);
        end
        m_read_byte(1'b0, d1);
        m_read_byte(1'b1, d2);
        total++;
        if (d1 !== 8'h5A || d2 !== 8'hA5) begin
            bad++; $display("FAIL rs_read got=%h_%h want=5a_a5", d1, d2);
        end
        m_stop();
        cyc(10);
        total++;
        if (start_cnt - s0 != 2 || stop_cnt - p0 != 1 || busy !== 1'b0) begin
            bad++; $display("FAIL rs_events got=st%0d sp%0d busy%b want=st2 sp1 busy0",
                            start_cnt - s0, stop_cnt - p0, busy);
        end
        total++;
        if (exp_q.size() != 0 || tx_src_q.size() != 0) begin
            bad++; $display("FAIL rs_queues got=%0d/%0d want=0/0", exp_q.size(), tx_src_q.size());
        end
    endtask

    task automatic test_glitch();
        logic ack;
        m_start();
        m_write_byte(8'hA0, 3, ack);
        total++;
        if (ack !== 1'b0 || addressed !== 1'b1) begin
            bad++; $display("FAIL gl_addr got=ack%b adr%b want=ack0 adr1", ack, addressed);
        end
        exp_q.push_back(8'h77);
        m_write_byte(8'h77, -1, ack);
        m_stop();
        cyc(10);
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL gl_rx_missing got=%0d want=0", exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        logic s;
        logic [7:0] a = 8'hA0;
        logic [9:0] got;
        m_start();
        for (int i = 0; i < 8; i++) m_bit(a[7-i], 1'b0, s);
        m_sda = 1'b1;
        total++;
        if (sda_oen !== 1'b0 || dut.state_q !== S_ADDR_ACK) begin
            bad++; $display("FAIL rm_pre got=sda%b st%0d want=sda0 st%0d", sda_oen, dut.state_q, S_ADDR_ACK);
        end
        rst = 1'b1;
        cyc(1);
        got = {scl_oen, sda_oen, rx_valid, tx_ready, start_p, stop_p, addressed, busy, dut.state_q == S_IDLE, 1'b0};
        total++;
        if (got !== 10'b11_0000_00_1_0) begin
            bad++; $display("FAIL rm_reset got=%b want=1100000010", got);
        end
        rst = 1'b0;
        cyc(10);
        m_stop();
        cyc(10);
    endtask

    task automatic test_disable();
        logic ack;
        en = 1'b0;
        m_start();
        m_write_byte(8'hA0, -1, ack);
        total++;
        if (ack !== 1'b1 || busy !== 1'b1 || addressed !== 1'b0) begin
            bad++; $display("FAIL dis_bus got=ack%b busy%b adr%b want=ack1 busy1 adr0", ack, busy, addressed);
        end
        m_stop();
        cyc(10);
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL dis_busy got=%b want=0", busy); end
        en = 1'b1;
        cyc(10);
    endtask

    initial begin
        test_reset();
        test_write();
        test_wrong_addr();
        test_read_stretch();
        test_repeated_start();
        test_glitch();
        test_reset_mid();
        test_disable();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
